// File: rtl/edge_event_if.sv
// edge_event_if: event-consumer bus plus level inputs and overflow controls
// slave  = arbiter side: takes level/ev_ready/clr_ovf, drives ev_*/overflow
// master = environment side: the mirror image
interface edge_event_if #(
  parameter int N    = 4,
  parameter int ID_W = 2
);
  logic [N-1:0]    level;
  logic            ev_valid;
  logic            ev_ready;
  logic [ID_W-1:0] ev_chan;
  logic            ev_pol;
  logic            ev_ovf;
  logic [N-1:0]    overflow;
  logic            clr_ovf;
  modport slave (
    input  level, ev_ready, clr_ovf,
    output ev_valid, ev_chan, ev_pol, ev_ovf, overflow
  );
  modport master (
    output level, ev_ready, clr_ovf,
    input  ev_valid, ev_chan, ev_pol, ev_ovf, overflow
  );
endinterface

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: per-channel edge capture with one-deep slots, round-robin offer to one consumer
// clk, rst : clock, asynchronous active-high reset
// bus      : slave side of edge_event_if (level in, ev_valid/ev_chan/ev_pol/ev_ovf out,
//            ev_ready in, overflow out, clr_ovf in)
module edge_event_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input logic         clk,
  input logic         rst,
  edge_event_if.slave bus
);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t          r_state;
  logic [N-1:0]    r_prev, r_pend, r_pol, r_dov, r_ovf;
  logic [ID_W-1:0] r_last, r_chan;
  logic            r_valid, r_evpol, r_evovf;
  logic [N-1:0]    w_rise, w_edge, w_pop, w_cap, w_drop, w_rot;
  logic [ID_W-1:0] w_sel;
  assign w_rise = ~r_prev & bus.level;
  assign w_edge = r_prev ^ bus.level;
  assign w_pop  = {N{r_valid & bus.ev_ready}} & (N'(1) << r_chan);
  // a slot popped this cycle is free again, so an edge landing on it is captured
  assign w_cap  = w_edge & (~r_pend | w_pop);
  assign w_drop = w_edge & r_pend & ~w_pop;
  // rotate so bit 0 is channel last+1; the lowest set bit is the round-robin winner
  assign w_rot  = N'({r_pend, r_pend} >> ((int'(r_last) + 1) % N));
  always_comb begin
    w_sel = '0;
    for (int j = N - 1; j >= 0; j--)
      if (w_rot[j]) w_sel = ID_W'((int'(r_last) + 1 + j) % N);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_prev  <= '0;
      r_pend  <= '0;
      r_pol   <= '0;
      r_dov   <= '0;
      r_ovf   <= '0;
      r_last  <= ID_W'(N - 1);
      r_chan  <= '0;
      r_valid <= 1'b0;
      r_evpol <= 1'b0;
      r_evovf <= 1'b0;
    end else begin
      r_prev <= bus.level;
      r_pend <= (r_pend & ~w_pop) | w_cap;
      r_pol  <= (r_pol & ~w_cap) | (w_rise & w_cap);
      r_dov  <= (r_dov & ~w_cap) | w_drop;
      r_ovf  <= (bus.clr_ovf ? '0 : r_ovf) | w_drop;
      if (r_state == IDLE) begin
        if (|r_pend) begin
          r_state <= OFFER;
          r_valid <= 1'b1;
          r_chan  <= w_sel;
          r_evpol <= r_pol[w_sel];
          r_evovf <= r_dov[w_sel];
        end
      end else if (bus.ev_ready) begin
        r_state <= IDLE;
        r_valid <= 1'b0;
        r_last  <= r_chan;
      end
    end
  end
  assign bus.ev_valid = r_valid;
  assign bus.ev_chan  = r_chan;
  assign bus.ev_pol   = r_evpol;
  assign bus.ev_ovf   = r_evovf;
  assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed vector table plus stall and async-reset sequences
module tb_edge_event_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  edge_event_if #(.N(4), .ID_W(2)) bus();
  edge_event_arbiter #(.N(4), .ID_W(2)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct packed {
    logic       r;
    logic [3:0] l;
    logic       y;
    logic       c;
    logic [8:0] e;
  } vec_t;
  vec_t tbl[$];
  int errs = 0;
  int checks = 0;
  function automatic logic [8:0] outs();
    return {bus.ev_valid, bus.ev_chan, bus.ev_pol, bus.ev_ovf, bus.overflow};
  endfunction
  function automatic logic [8:0] ex(logic v, logic [1:0] ch, logic p, logic eo, logic [3:0] o);
    return {v, ch, p, eo, o};
  endfunction
  task automatic check(string name, logic [8:0] exp);
    logic [8:0] got;
    got = outs();
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: {valid,chan,pol,ev_ovf,overflow} got %b required %b", name, got, exp);
    end
  endtask
  task automatic add(logic r, logic [3:0] l, logic y, logic c,
                     logic v, logic [1:0] ch, logic p, logic eo, logic [3:0] o);
    vec_t t;
    t.r = r; t.l = l; t.y = y; t.c = c; t.e = ex(v, ch, p, eo, o);
    tbl.push_back(t);
  endtask
  task automatic drive(logic r, logic [3:0] l, logic y, logic c);
    rst = r; bus.level = l; bus.ev_ready = y; bus.clr_ovf = c;
    @(negedge clk);
  endtask
  initial begin
    bus.level = '0; bus.ev_ready = 1'b0; bus.clr_ovf = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", ex(0, 0, 0, 0, 4'h0));
    // single rise on channel 2
    add(1, 4'h0, 1, 0, 0, 0, 0, 0, 4'h0);
    add(0, 4'h0, 1, 0, 0, 0, 0, 0, 4'h0);
    add(0, 4'h4, 1, 0, 0, 0, 0, 0, 4'h0);
    add(0, 4'h4, 1, 0, 1, 2, 1, 0, 4'h0);
    add(0, 4'h4, 1, 0, 0, 2, 1, 0, 4'h0);
    add(0, 4'h4, 1, 0, 0, 2, 1, 0, 4'h0);
    // all channels rise together, then all fall
    add(1, 4'h0, 1, 0, 0, 0, 0, 0, 4'h0);
    add(0, 4'hF, 1, 0, 0, 0, 0, 0, 4'h0);
    add(0, 4'hF, 1, 0, 1, 0, 1, 0, 4'h0);
    add(0, 4'hF, 1, 0, 0, 0, 1, 0, 4'h0);
    add(0, 4'hF, 1, 0, 1, 1, 1, 0, 4'h0);
    add(0, 4'hF, 1, 0, 0, 1, 1, 0, 4'h0);
    add(0, 4'hF, 1, 0, 1, 2, 1, 0, 4'h0);
    add(0, 4'hF, 1, 0, 0, 2, 1, 0, 4'h0);
    add(0, 4'hF, 1, 0, 1, 3, 1, 0, 4'h0);
    add(0, 4'hF, 1, 0, 0, 3, 1, 0, 4'h0);
    add(0, 4'h0, 1, 0, 0, 3, 1, 0, 4'h0);
    add(0, 4'h0, 1, 0, 1, 0, 0, 0, 4'h0);
    add(0, 4'h0, 1, 0, 0, 0, 0, 0, 4'h0);
    add(0, 4'h0, 1, 0, 1, 1, 0, 0, 4'h0);
    add(0, 4'h0, 1, 0, 0, 1, 0, 0, 4'h0);
    add(0, 4'h0, 1, 0, 1, 2, 0, 0, 4'h0);
    add(0, 4'h0, 1, 0, 0, 2, 0, 0, 4'h0);
    add(0, 4'h0, 1, 0, 1, 3, 0, 0, 4'h0);
    add(0, 4'h0, 1, 0, 0, 3, 0, 0, 4'h0);
    // channel 1 rise, then fall/rise/fall while stalled: drops flagged
    add(1, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0);
    add(0, 4'h2, 0, 0, 0, 0, 0, 0, 4'h0);
    add(0, 4'h0, 0, 0, 1, 1, 1, 0, 4'h2);
    add(0, 4'h2, 0, 0, 1, 1, 1, 0, 4'h2);
    add(0, 4'h0, 0, 0, 1, 1, 1, 0, 4'h2);
    add(0, 4'h0, 1, 0, 0, 1, 1, 0, 4'h2);
    // drop on a pending (not yet offered) channel shows up as ev_ovf
    add(0, 4'h1, 0, 0, 0, 1, 1, 0, 4'h2);
    add(0, 4'h1, 0, 0, 1, 0, 1, 0, 4'h2);
    add(0, 4'h5, 0, 0, 1, 0, 1, 0, 4'h2);
    add(0, 4'h1, 0, 0, 1, 0, 1, 0, 4'h6);
    add(0, 4'h1, 1, 0, 0, 0, 1, 0, 4'h6);
    add(0, 4'h1, 0, 0, 1, 2, 1, 1, 4'h6);
    add(0, 4'h1, 1, 1, 0, 2, 1, 1, 4'h0);
    // set and clear in the same cycle: set wins
    add(0, 4'h0, 0, 0, 0, 2, 1, 1, 4'h0);
    add(0, 4'h0, 0, 0, 1, 0, 0, 0, 4'h0);
    add(0, 4'h1, 0, 1, 1, 0, 0, 0, 4'h1);
    add(0, 4'h1, 0, 1, 1, 0, 0, 0, 4'h0);
    // handshake on channel 3 in the same cycle channel 3 falls
    add(0, 4'h9, 0, 0, 1, 0, 0, 0, 4'h0);
    add(0, 4'h9, 1, 0, 0, 0, 0, 0, 4'h0);
    add(0, 4'h9, 0, 0, 1, 3, 1, 0, 4'h0);
    add(0, 4'h1, 1, 0, 0, 3, 1, 0, 4'h0);
    add(0, 4'h1, 1, 0, 1, 3, 0, 0, 4'h0);
    add(0, 4'h1, 1, 0, 0, 3, 0, 0, 4'h0);
    add(0, 4'h1, 1, 0, 0, 3, 0, 0, 4'h0);
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].l, tbl[i].y, tbl[i].c);
      check($sformatf("vec%0d", i), tbl[i].e);
    end
    // stall: offer must hold for 10 cycles with ev_ready low
    drive(0, 4'h3, 0, 0);
    check("stall_pend", ex(0, 3, 0, 0, 4'h0));
    for (int k = 0; k < 10; k++) begin
      drive(0, 4'h3, 0, 0);
      check($sformatf("stall%0d", k), ex(1, 1, 1, 0, 4'h0));
    end
    drive(0, 4'h3, 1, 0);
    check("stall_hs", ex(0, 1, 1, 0, 4'h0));
    drive(0, 4'h3, 1, 0);
    check("stall_clear", ex(0, 1, 1, 0, 4'h0));
    // asynchronous reset in the middle of an offer
    drive(0, 4'h7, 0, 0);
    drive(0, 4'h7, 0, 0);
    check("pre_rst_offer", ex(1, 2, 1, 0, 4'h0));
    rst = 1'b1;
    #1;
    check("async_rst", ex(0, 0, 0, 0, 4'h0));
    @(negedge clk);
    drive(0, 4'h1, 0, 0);
    check("post_rst_pend", ex(0, 0, 0, 0, 4'h0));
    drive(0, 4'h1, 0, 0);
    check("post_rst_offer", ex(1, 0, 1, 0, 4'h0));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
